// File: rtl/rf_multiport_sb_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// scoreboard issue/flush controls and the debug busy vector.
interface rf_multiport_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [2**ADDR_W-1:0]     busy_vec;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-read / dual-write register file with write-through bypass and a
// per-register result-pending scoreboard for the pipelined MIPS32 core.
module rf_multiport_sb #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter int              NUM_RD  = 2,
    parameter int              SP_IDX  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_07FF
) (
    input  logic               clk,
    input  logic               rst,
    rf_multiport_sb_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Write port 1 is applied after port 0 so the younger stage wins a conflict;
    // issue beats a simultaneous writeback because it names a new producer.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.wr0_en && bus.wr0_addr == ADDR_W'(i)) regs_d[i] = bus.wr0_data;
            if (bus.wr1_en && bus.wr1_addr == ADDR_W'(i)) regs_d[i] = bus.wr1_data;
            if (bus.flush)
                busy_d[i] = 1'b0;
            else if (bus.iss_en && bus.iss_addr == ADDR_W'(i))
                busy_d[i] = 1'b1;
            else if ((bus.wr0_en && bus.wr0_addr == ADDR_W'(i)) ||
                     (bus.wr1_en && bus.wr1_addr == ADDR_W'(i)))
                busy_d[i] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++)
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] rdVal;
        logic              wrHit;

        assign rdAddr = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign wrHit  = (rdAddr != '0) &&
                        ((bus.wr0_en && bus.wr0_addr == rdAddr) ||
                         (bus.wr1_en && bus.wr1_addr == rdAddr));

        // Bypass is suppressed during reset so readers see the reset contents.
        always_comb begin
            rdVal = '0;
            for (int j = 1; j < DEPTH; j++)
                if (rdAddr == ADDR_W'(j)) rdVal = regs_q[j];
            if (!rst && rdAddr != '0) begin
                if (bus.wr0_en && bus.wr0_addr == rdAddr) rdVal = bus.wr0_data;
                if (bus.wr1_en && bus.wr1_addr == rdAddr) rdVal = bus.wr1_data;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = rdVal;
        assign bus.rd_busy[k] = busy_q[rdAddr] & ~wrHit;
    end
endmodule
